// File: rtl/mips_test_sequencer.sv
// Program-driven stimulus sequencer for mips_cpu_harvard directed tests.
// Fetch path is combinational (zero latency); run result is registered one cycle after halt/timeout.
// No handshake backpressure: start/prog_we are simply ignored while a run is in progress.
module mips_test_sequencer #(
  parameter int unsigned PROG_DEPTH       = 16,
  parameter logic [31:0] ADDR_BASE        = 32'hBFC00000,
  parameter int unsigned TIMEOUT_CYCLES   = 10000,
  parameter int unsigned CPU_RESET_CYCLES = 2,
  parameter int unsigned STALL_PERIOD     = 0,
  localparam int unsigned AW              = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_waddr,
  input  logic [31:0]   prog_wdata,
  input  logic [31:0]   expected_v0,
  output logic          cpu_reset,
  output logic          cpu_clk_enable,
  input  logic [31:0]   instr_address,
  output logic [31:0]   instr_readdata,
  input  logic          cpu_active,
  input  logic [31:0]   register_v0,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [31:0]   cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_CPU_RST, S_RUN, S_DONE} state_e;

  localparam bit          STALL_EN   = (STALL_PERIOD >= 2);
  localparam logic [31:0] STALL_LAST = STALL_EN ? 32'(STALL_PERIOD - 1) : 32'd0;
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RST_LAST   = 32'(CPU_RESET_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] rst_cnt_q, rst_cnt_d;
  // Phase of the stall pattern: equals cycle_count mod STALL_PERIOD without a divider.
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        seen_q, seen_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [31:0] prog_q [PROG_DEPTH];

  logic        idle_or_done;
  logic        start_ok;
  logic        halt;
  logic        last_cyc;
  logic        stall;
  logic [31:0] offset;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok     = start && idle_or_done;
  assign halt         = (state_q == S_RUN) && !cpu_active && seen_q;
  assign last_cyc     = (cycle_q == TO_LAST);
  assign stall        = STALL_EN && (stall_cnt_q == STALL_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; halt takes priority over timeout in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CPU_RST;
      S_CPU_RST: if (rst_cnt_q == RST_LAST) state_d = S_RUN;
      S_RUN:     if (halt || last_cyc) state_d = S_DONE;
      S_DONE:    if (start) state_d = S_CPU_RST;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode; reset forces the CPU into reset without waiting for the edge
  always_comb begin
    cpu_reset      = 1'b1;
    cpu_clk_enable = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state_q)
      S_CPU_RST: begin
        busy           = 1'b1;
        cpu_clk_enable = 1'b1;
      end
      S_RUN: begin
        busy           = 1'b1;
        cpu_reset      = 1'b0;
        cpu_clk_enable = !stall;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
    if (reset) begin
      cpu_reset      = 1'b1;
      cpu_clk_enable = 1'b0;
    end
  end

  // Run bookkeeping: counters, seen-active flag and the sampled verdict
  always_comb begin
    cycle_d     = cycle_q;
    rst_cnt_d   = rst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    seen_d      = seen_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    if (start_ok) begin
      cycle_d     = 32'd0;
      rst_cnt_d   = 32'd0;
      stall_cnt_d = 32'd0;
      seen_d      = 1'b0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        S_CPU_RST: rst_cnt_d = rst_cnt_q + 32'd1;
        S_RUN: begin
          cycle_d = cycle_q + 32'd1;
          if (STALL_EN) stall_cnt_d = stall ? 32'd0 : stall_cnt_q + 32'd1;
          if (cpu_active) seen_d = 1'b1;
          if (halt) begin
            pass_d    = (register_v0 == expected_v0);
            timeout_d = 1'b0;
          end else if (last_cyc) begin
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q     <= 32'd0;
      rst_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
      seen_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      cycle_q     <= cycle_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      seen_q      <= seen_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  // Program store: writable only while no run is in progress, never cleared
  always_ff @(posedge clk) begin
    if (prog_we && idle_or_done) prog_q[prog_waddr] <= prog_wdata;
  end

  // Instruction fetch: word-aligned addresses inside the window hit, all else reads as NOP
  always_comb begin
    offset         = instr_address - ADDR_BASE;
    instr_readdata = 32'h00000000;
    if ((offset[1:0] == 2'b00) && (offset[31:AW+2] == '0))
      instr_readdata = prog_q[offset[AW+1:2]];
  end

  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;

endmodule
